// File: rtl/quad_enc_emul.sv
// Quadrature encoder emulator: generates registered A/B/Z channels and a
// matching position count from a programmable edge period and direction.
module quad_enc_emul #(
    parameter int LINES      = 1024,  // encoder lines per revolution
    parameter int MIN_PERIOD = 96,    // floor on clocks between channel edges
    parameter int POS_W      = 12     // position width, clog2(4*LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [15:0]      period,
    output logic             cha,
    output logic             chb,
    output logic             chz,
    output logic [POS_W-1:0] pos,
    output logic             step
);

    localparam int              CPR     = 4 * LINES;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(CPR - 1);
    localparam logic [15:0]     MIN_P   = 16'(MIN_PERIOD);

    // Elaboration-time guards on parameter combinations that cannot work.
    if (MIN_PERIOD < 82) begin : g_min_period_check
        $error("quad_enc_emul: MIN_PERIOD must be at least 82");
    end
    if (POS_W != $clog2(CPR)) begin : g_pos_w_check
        $error("quad_enc_emul: POS_W must equal clog2(4*LINES)");
    end

    // Channel state, encoded directly as {A,B} so the outputs need no decode.
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b10,
        S2 = 2'b11,
        S3 = 2'b01
    } phase_e;

    logic [15:0]      cnt_q, cnt_d;
    phase_e           phase_q, phase_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             armed_q, armed_d;
    logic             chz_q, chz_d;
    logic             step_q, step_d;

    logic [15:0]      eff_period;
    logic             running;
    logic             fire;

    // Prescaler: clamp the requested period and decide whether this cycle steps.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        eff_period = (period > MIN_P) ? period : MIN_P;
        running    = en && (period != 16'd0);
        // eff_period >= 82 here, so the subtraction cannot underflow. Using >=
        // rather than == makes a freshly lowered period fire on the next edge.
        fire       = running && (cnt_q >= (eff_period - 16'd1));
        cnt_d      = cnt_q;
        if (!running || fire) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Phase FSM next state: one Gray move per step, direction sampled on the step.
    always_comb begin
        phase_d = phase_q;
        if (fire) begin
            unique case (phase_q)
                S0:      phase_d = dir ? S1 : S3;
                S1:      phase_d = dir ? S2 : S0;
                S2:      phase_d = dir ? S3 : S1;
                S3:      phase_d = dir ? S0 : S2;
                default: phase_d = S0;
            endcase
        end
    end

    // Position, index arming and index/step outputs, all aligned to the step edge.
    always_comb begin
        pos_d   = pos_q;
        armed_d = armed_q;
        if (fire) begin
            armed_d = 1'b1;
            if (dir) begin
                pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
            end else begin
                pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
            end
        end
        chz_d  = armed_d && (pos_d == '0);
        step_d = fire;
    end

    // State register with synchronous reset that overrides every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            cnt_q   <= 16'd0;
            phase_q <= S0;
            pos_q   <= '0;
            armed_q <= 1'b0;
            chz_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            armed_q <= armed_d;
            chz_q   <= chz_d;
            step_q  <= step_d;
        end
    end

    assign cha  = phase_q[1];
    assign chb  = phase_q[0];
    assign chz  = chz_q;
    assign pos  = pos_q;
    assign step = step_q;

endmodule
